wallace_final_adder: RTL
========================

# wallace_final_adder

Final carry-propagate stage of the 1024-bit Wallace multiplier. It accepts the redundant sum and carry vectors produced by the Wallace compression tree and resolves them into the binary product. Resolution is multi-cycle: one CHUNK-bit ripple slice per clock, reusing the team's 4-bit carry-in/carry-out adder slice. Valid/ready handshakes connect it to the tree upstream and the product consumer downstream.

## Interface
- WIDTH, 2048, operand width (2 × 1024); must be a multiple of CHUNK
- CHUNK, 4, bits resolved per cycle; N = WIDTH/CHUNK cycles per full add
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream presents sum_vec/carry_vec
- in_ready  output  1  block can accept an operand pair
- sum_vec  input  WIDTH  Wallace sum vector
- carry_vec  input  WIDTH  Wallace carry vector, already shifted into weight alignment by the tree
- out_valid  output  1  result holds a valid product
- out_ready  input  1  downstream accepts result
- result  output  WIDTH+1  sum_vec + carry_vec; bit WIDTH is the final carry-out
- busy  output  1  high in ADD or DONE

## Operation
- One clock, clk. Reset is synchronous and active-high on rst.
- FSM states: IDLE, ADD, DONE. Reset enters IDLE.
- IDLE: in_ready=1. When in_valid && in_ready at an edge:
  - capture sum_vec and carry_vec into operand shift registers A and B;
  - clear result, chunk index k=0 and carry c=0;
  - go to ADD.
- ADD: one edge per chunk.
  - Compute {c', s} = A[CHUNK-1:0] + B[CHUNK-1:0] + c.
  - Write s into result[k*CHUNK +: CHUNK].
  - Shift A and B right by CHUNK (zero fill); c <= c'; k <= k+1.
  - After chunk N-1: write result[WIDTH] = c' and go to DONE.
- DONE: out_valid=1 and result held stable. When out_ready, go to IDLE at that edge.
  - in_ready is low in DONE, so a new accept occurs no earlier than the following cycle.
- Arithmetic is unsigned and exact. result = sum_vec + carry_vec, modulo 2^(WIDTH+1), which never wraps.
- in_valid is ignored outside IDLE. sum_vec and carry_vec may change freely after the accept edge.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, result=0. Internal state: A=B=0, k=0, c=0.
- Accept at edge E0. Chunk j is written at edge E0+j+1. out_valid rises at edge E0+N, giving latency N cycles (512 at default).
- out_valid stays high until the edge where out_ready=1, then drops. Back-to-back throughput is one result per N+2 cycles.
- Reset mid-operation (ADD or DONE): the next edge forces the reset values, the in-flight result is discarded, and out_valid never asserts for it.
- Simultaneous rst and any handshake: rst wins.
- out_ready while not in DONE has no effect.

## Configuration
- FINAL_ADD_EARLY_EXIT_EN defined:
  - In ADD, if the shifted A and B are both zero after writing chunk k, set result bit (k+1)*CHUNK = c' and go directly to DONE.
  - The remaining result bits stay 0 from the clear.
  - Latency becomes k+1 cycles, where k is the index of the highest chunk containing any nonzero bit of either operand; minimum 1 cycle.
  - The result value is identical to the full-latency path.
- Undefined: latency is always exactly N cycles regardless of operand values.

## Test plan
Bench uses WIDTH=16, CHUNK=4 (N=4).
- Reset: assert rst for 2 cycles -> in_ready=1, out_valid=0, busy=0, result=0x00000.
- Accept sum_vec=0xFFFF, carry_vec=0x0001 -> result=0x10000 with out_valid exactly 4 cycles after accept, in both configurations.
- Accept 0x00FF + 0x0001 -> result=0x00100. Latency is 4 cycles without the macro and 2 cycles with FINAL_ADD_EARLY_EXIT_EN.
- Accept 0x0000 + 0x0000 -> result=0x00000. Latency is 4 cycles without the macro and 1 cycle with it.
- Backpressure: complete 0x1234 + 0x4321, then hold out_ready=0 for 5 cycles while pulsing in_valid with other data.
  - Required: result=0x05555 held stable, in_ready=0, no new accept.
  - Then out_ready=1 -> IDLE next cycle.
- Reset mid-op: accept 0xABCD + 0x1111, assert rst at accept+2.
  - Required: out_valid never rises and the outputs return to reset values.
  - A following 0x0F0F + 0xF0F1 must produce 0x10000.

Source files
------------

// File: rtl/wallace_final_adder_if.sv
// Handshake bundle between the Wallace tree, the final adder and the product consumer.
interface wallace_final_adder_if #(
    parameter int WIDTH = 2048
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_vec;
    logic [WIDTH-1:0] carry_vec;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   result;
    logic             busy;

    modport master (
        output in_valid, sum_vec, carry_vec, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, sum_vec, carry_vec, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/wallace_final_adder.sv
// Multi-cycle carry-propagate adder resolving Wallace sum/carry vectors, one CHUNK slice per clock.
// Optional FINAL_ADD_EARLY_EXIT_EN stops as soon as the remaining operand bits are all zero.
module wallace_final_adder_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_c,
    output logic [CHUNK-1:0] o_s,
    output logic             o_c
);
    assign {o_c, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_c};
endmodule

module wallace_final_adder #(
    parameter int WIDTH = 2048,
    parameter int CHUNK = 4
) (
    input logic                 clk,
    input logic                 rst,
    wallace_final_adder_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH:0]   r_res;
    logic [KW-1:0]    r_k;
    logic             r_c;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [CHUNK-1:0] w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [IW-1:0]    w_lo;
    logic [IW-1:0]    w_cbit;
    logic             w_last;
    logic             w_exit;

    wallace_final_adder_slice #(.CHUNK(CHUNK)) u_slice (
        .i_a (r_a[CHUNK-1:0]),
        .i_b (r_b[CHUNK-1:0]),
        .i_c (r_c),
        .o_s (w_s),
        .o_c (w_c)
    );

    assign w_a_nxt = r_a >> CHUNK;
    assign w_b_nxt = r_b >> CHUNK;
    assign w_lo    = IW'(r_k) * IW'(CHUNK);
    // On the final chunk this lands on bit WIDTH, the carry-out
    assign w_cbit  = w_lo + IW'(CHUNK);
    assign w_last  = (r_k == KW'(N - 1));

`ifdef FINAL_ADD_EARLY_EXIT_EN
    assign w_exit = w_last || ((w_a_nxt == '0) && (w_b_nxt == '0));
`else
    assign w_exit = w_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_k         <= '0;
            r_c         <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.sum_vec;
                        r_b        <= bus.carry_vec;
                        r_res      <= '0;
                        r_k        <= '0;
                        r_c        <= 1'b0;
                        r_state    <= ADD;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ADD: begin
                    r_res[w_lo +: CHUNK] <= w_s;
                    r_a <= w_a_nxt;
                    r_b <= w_b_nxt;
                    r_c <= w_c;
                    r_k <= r_k + 1'b1;
                    if (w_exit) begin
                        r_res[w_cbit] <= w_c;
                        r_state       <= DONE;
                        r_out_valid   <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_res;
    assign bus.busy      = r_busy;
endmodule
